wash_phase_timer: RTL and testbench
===================================

// Module: wash_phase_timer
// PURPOSE
//  Phase-duration scheduler for the coin-operated washer controller.
//  - Watches the controller's one-hot phase outputs (molho, lavar, enxague, centrifugar, pausar).
//  - Times each phase and returns a one-cycle tempo pulse that advances the controller.
//  - Freezes the spin timer while paused (lid open) and resumes it afterwards.
//  - Flags illegal phase encodings.
// PARAMETERS
//  PRESCALE  50  clk cycles per timer tick (>=1)
//  CNT_W     8   width of the phase countdown counter
//  T_MOLHO   20  soak duration, ticks
//  T_LAVAR   40  wash duration, ticks
//  T_ENXAG   30  rinse duration, ticks
//  T_CENTR   25  spin duration, ticks
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-low
//  molho        in   1      soak phase active
//  lavar        in   1      wash phase active (first or second wash)
//  enxague      in   1      rinse phase active (first or second rinse)
//  centrifugar  in   1      spin phase active
//  pausar       in   1      spin paused, lid open
//  tempo        out  1      phase-elapsed pulse to the washer controller, 1 clk wide
//  remaining    out  CNT_W  ticks left in the current phase
//  busy         out  1      timer counting (RUN)
//  err          out  1      more than one phase input high
// BEHAVIOUR
//  - Reset (reset=0): state=IDLE; tempo=0, remaining=0, busy=0, err=0; prescaler=0; prev_phase=none.
//  - Phase inputs are sampled on each rising clk edge; prev_phase register holds the last sample.
//  - Phase change = sampled phase differs from prev_phase.
//  - Duration D: selected from T_* by the new phase. D=0 is treated as 1.
//  - Tick: prescaler counts 0..PRESCALE-1 in RUN only.
//    - Tick is true on the clk where prescaler==PRESCALE-1; prescaler then wraps to 0.
//  - States:
//    - IDLE: no phase input high. Counter and prescaler held.
//      - Single timed phase seen -> load remaining=D, prescaler=0 -> RUN.
//    - RUN: remaining decrements on each tick.
//      - Tick with remaining==1: remaining<=0, tempo<=1 for exactly one clk -> DONE.
//      - Latency: tempo is high in the clk starting D*PRESCALE edges after the load edge.
//    - DONE: no further pulses.
//      - New timed phase -> reload D -> RUN.
//      - All inputs low -> IDLE.
//    - HOLD: entered from RUN/DONE when pausar is sampled.
//      - remaining and prescaler frozen; tempo=0; busy=0.
//      - centrifugar sampled with remaining!=0 -> RUN, resumes the frozen count and prescaler (no reload).
//      - Any other timed phase -> reload its D -> RUN.
//      - All inputs low -> IDLE.
//  - Phase change seen in RUN (controller advanced early): discard the count, reload the new D, no tempo.
//  - Same phase sampled continuously: never reloads.
//    - A lavar->enxague->lavar sequence reloads at each change.
//  - Illegal encoding (>1 input high):
//    - err=1 that cycle; state forced to IDLE; remaining=0; tempo=0.
//    - Resumes normally on the next legal sample.
//  - Simultaneous tick-expiry and phase change: the phase change wins.
//    - The new D is loaded and tempo stays 0.
//  - reset asserted mid-phase: immediate return to the reset values, pending pulse dropped.
//  - remaining saturates at 0; it never wraps.
// TESTING
//  1. PRESCALE=1, T_MOLHO=3, molho rises at edge 0 -> tempo=1 only between edges 3 and 4; remaining 3,2,1,0.
//  2. Full cycle molho->lavar->enxague->centrifugar, each driven by tempo
//     -> pulses after 20/40/30/25 ticks; busy low only in DONE/IDLE.
//  3. Spin with T_CENTR=10, pausar at remaining=6 for 100 clks, then centrifugar
//     -> remaining stays 6 throughout the pause; tempo 6 ticks after resume.
//  4. molho and lavar both high -> err=1, remaining=0, no tempo; next clk molho only -> loads T_MOLHO.
//  5. reset low while remaining=15 in lavar -> remaining=0, tempo=0, busy=0 asynchronously;
//     release with lavar still high -> reload 40.
//  6. PRESCALE=4, T_ENXAG=0 -> treated as 1, tempo exactly 4 clks after load;
//     phase change on the expiry edge -> reload, no tempo.

Source files
------------

// File: rtl/wash_phase_timer.sv
// wash_phase_timer: times each phase of the coin-operated washer controller.
// Each phase lasts a fixed number of ticks. When a phase has run its full
// duration, the block sends a one-clock tempo pulse that moves the controller
// to the next phase.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   molho        soak phase active
//   lavar        wash phase active
//   enxague      rinse phase active
//   centrifugar  spin phase active
//   pausar       spin paused (lid open)
//   tempo        phase-elapsed pulse, one clk wide
//   remaining    ticks left in the current phase
//   busy         timer counting
//   err          more than one phase input high on the last sample
module wash_phase_timer #(
    parameter int PRESCALE = 50,
    parameter int CNT_W    = 8,
    parameter int T_MOLHO  = 20,
    parameter int T_LAVAR  = 40,
    parameter int T_ENXAG  = 30,
    parameter int T_CENTR  = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             molho,
    input  logic             lavar,
    input  logic             enxague,
    input  logic             centrifugar,
    input  logic             pausar,
    output logic             tempo,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             err
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [4:0]       prev_q, prev_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tempo_q, tempo_d;
    logic             err_q, err_d;

    // Bit order: molho, lavar, enxague, centrifugar, pausar.
    logic [4:0] phase;
    logic       multi, none, paused, changed, tick;
    logic [CNT_W-1:0] dur;

    assign phase   = {molho, lavar, enxague, centrifugar, pausar};
    // Clearing the lowest set bit leaves something only if two or more bits are set.
    assign multi   = (phase & (phase - 5'd1)) != 5'd0;
    assign none    = phase == 5'd0;
    assign paused  = phase == 5'b00001;
    assign changed = phase != prev_q;
    assign tick    = presc_q == PRESC_LAST;

    always_comb begin
        dur = '0;
        case (phase)
            5'b10000: dur = CNT_W'(T_MOLHO);
            5'b01000: dur = CNT_W'(T_LAVAR);
            5'b00100: dur = CNT_W'(T_ENXAG);
            5'b00010: dur = CNT_W'(T_CENTR);
            default:  dur = '0;
        endcase
        // A zero-length phase still has to produce a pulse, so it counts as one tick.
        if (dur == '0) dur = CNT_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = phase;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        tempo_d     = 1'b0;
        err_d       = 1'b0;

        if (multi) begin
            state_d     = IDLE;
            remaining_d = '0;
            presc_d     = '0;
            err_d       = 1'b1;
        end else if (none) begin
            state_d = IDLE;
        end else if (paused) begin
            if (state_q == RUN || state_q == DONE) state_d = HOLD;
        end else begin
            // Exactly one timed phase is high.
            case (state_q)
                IDLE: begin
                    remaining_d = dur;
                    presc_d     = '0;
                    state_d     = RUN;
                end
                RUN: begin
                    if (changed) begin
                        // The controller moved on early. Drop the old count. This
                        // also takes priority over a tick expiring on the same edge.
                        remaining_d = dur;
                        presc_d     = '0;
                    end else begin
                        presc_d = tick ? '0 : presc_q + PW'(1);
                        if (tick) begin
                            if (remaining_q <= CNT_W'(1)) begin
                                remaining_d = '0;
                                tempo_d     = 1'b1;
                                state_d     = DONE;
                            end else begin
                                remaining_d = remaining_q - CNT_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    if (changed) begin
                        remaining_d = dur;
                        presc_d     = '0;
                        state_d     = RUN;
                    end
                end
                HOLD: begin
                    // Closing the lid on an unfinished spin picks up the frozen count.
                    if (!(centrifugar && remaining_q != '0)) begin
                        remaining_d = dur;
                        presc_d     = '0;
                    end
                    state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            remaining_q <= '0;
            presc_q     <= '0;
            tempo_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            tempo_q     <= tempo_d;
            err_q       <= err_d;
        end
    end

    assign tempo     = tempo_q;
    assign remaining = remaining_q;
    assign busy      = state_q == RUN;
    assign err       = err_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// tb_wash_phase_timer: randomized and directed stimulus for wash_phase_timer.
// A reference model works out the expected output for each stimulus and puts
// it in a queue. A separate monitor pops each expectation and compares it
// with the DUT output.
module tb_wash_phase_timer;

    localparam int P     = 2;
    localparam int W     = 8;
    localparam int TM    = 3;
    localparam int TL    = 5;
    localparam int TE    = 0;
    localparam int TC    = 10;

    localparam logic [4:0] PH_MOLHO = 5'b10000;
    localparam logic [4:0] PH_LAVAR = 5'b01000;
    localparam logic [4:0] PH_ENXAG = 5'b00100;
    localparam logic [4:0] PH_CENTR = 5'b00010;
    localparam logic [4:0] PH_PAUSE = 5'b00001;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;
    localparam int M_HOLD = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         molho = 1'b0, lavar = 1'b0, enxague = 1'b0, centrifugar = 1'b0, pausar = 1'b0;
    logic         tempo, busy, err;
    logic [W-1:0] remaining;

    wash_phase_timer #(
        .PRESCALE(P), .CNT_W(W), .T_MOLHO(TM), .T_LAVAR(TL), .T_ENXAG(TE), .T_CENTR(TC)
    ) dut (
        .clk(clk), .reset(reset), .molho(molho), .lavar(lavar), .enxague(enxague),
        .centrifugar(centrifugar), .pausar(pausar), .tempo(tempo), .remaining(remaining),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tempo;
        int rem;
        int busy;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // The model tracks how many RUN clocks are left before expiry. The
    // remaining output follows from that by ceiling division.
    int         m_mode = M_IDLE;
    int         m_left = 0;
    logic [4:0] m_prev = '0;
    int         m_tempo = 0;
    int         m_err = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    function automatic int eff_dur(input logic [4:0] p);
        int t;
        case (p)
            PH_MOLHO: t = TM;
            PH_LAVAR: t = TL;
            PH_ENXAG: t = TE;
            PH_CENTR: t = TC;
            default:  t = 0;
        endcase
        return (t == 0) ? 1 : t;
    endfunction

    function automatic int m_rem();
        return (m_left + P - 1) / P;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.tempo = m_tempo;
        e.rem   = m_rem();
        e.busy  = (m_mode == M_RUN) ? 1 : 0;
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_left = 0; m_prev = '0; m_tempo = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [4:0] p);
        int load;
        load    = eff_dur(p) * P;
        m_tempo = 0;
        m_err   = 0;
        if ($countones(p) > 1) begin
            m_mode = M_IDLE; m_left = 0; m_err = 1;
        end else if (p == 5'd0) begin
            m_mode = M_IDLE;
        end else if (p == PH_PAUSE) begin
            if (m_mode == M_RUN || m_mode == M_DONE) m_mode = M_HOLD;
        end else begin
            case (m_mode)
                M_IDLE: begin m_left = load; m_mode = M_RUN; end
                M_RUN: begin
                    if (p != m_prev) m_left = load;
                    else begin
                        m_left--;
                        if (m_left == 0) begin m_tempo = 1; m_mode = M_DONE; end
                    end
                end
                M_DONE: if (p != m_prev) begin m_left = load; m_mode = M_RUN; end
                default: begin
                    if (!(p == PH_CENTR && m_left != 0)) m_left = load;
                    m_mode = M_RUN;
                end
            endcase
        end
        m_prev = p;
        push_exp();
    endtask

    task automatic drive(input logic [4:0] p);
        @(negedge clk);
        reset = 1'b1;
        {molho, lavar, enxague, centrifugar, pausar} = p;
        model_step(p);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("async_reset_tempo", int'(tempo), 0);
        check("async_reset_remaining", int'(remaining), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_err", int'(err), 0);
        push_exp();
        for (int i = 1; i < cycles; i++) begin
            @(negedge clk);
            push_exp();
        end
    endtask

    task automatic run_until_tempo(input logic [4:0] p, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            drive(p);
            if (m_tempo != 0) return;
        end
        n_checks++; n_errors++;
        $display("FAIL wait_tempo: got no pulse expected one within %0d clks", maxc);
    endtask

    task automatic run_until_rem(input logic [4:0] p, input int target, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            drive(p);
            if (m_mode == M_RUN && m_rem() == target) return;
        end
        n_checks++; n_errors++;
        $display("FAIL wait_remaining: got no remaining=%0d expected within %0d clks", target, maxc);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tempo", int'(tempo), e.tempo);
                check("remaining", int'(remaining), e.rem);
                check("busy", int'(busy), e.busy);
                check("err", int'(err), e.err);
            end
        end
    end

    // Stimulus
    initial begin
        logic [4:0] p;
        int r, len, a, b;

        model_reset();
        repeat (2) begin @(negedge clk); push_exp(); end

        // Full cycle, with each phase advanced by the model's tempo.
        drive(5'd0);
        run_until_tempo(PH_MOLHO, 100);
        run_until_tempo(PH_LAVAR, 100);
        run_until_tempo(PH_ENXAG, 100);
        // Pause the spin at remaining=6 for 100 clks, then resume it.
        run_until_rem(PH_CENTR, 6, 100);
        repeat (100) drive(PH_PAUSE);
        run_until_tempo(PH_CENTR, 100);
        drive(PH_CENTR);
        drive(5'd0);

        // A zero-length rinse expires after P clks.
        drive(PH_ENXAG); drive(PH_ENXAG); drive(PH_ENXAG); drive(PH_ENXAG);
        // The phase changes on the expiry edge, so the new phase reloads with no pulse.
        drive(5'd0);
        drive(PH_ENXAG); drive(PH_ENXAG); drive(PH_LAVAR); drive(PH_LAVAR);

        // Illegal encoding, then a legal sample.
        drive(PH_MOLHO | PH_LAVAR);
        drive(PH_MOLHO);
        drive(PH_MOLHO);

        // Reset in the middle of a wash, released with lavar still high.
        drive(5'd0);
        drive(PH_LAVAR); drive(PH_LAVAR); drive(PH_LAVAR);
        do_reset(3);
        run_until_tempo(PH_LAVAR, 100);

        // Random segments.
        for (int s = 0; s < 250; s++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                p = 5'd0; len = $urandom_range(1, 6);
            end else if (r < 24) begin
                p = PH_PAUSE; len = $urandom_range(1, 15);
            end else if (r < 30) begin
                a = $urandom_range(0, 4);
                b = (a + 1 + $urandom_range(0, 3)) % 5;
                p = 5'd0;
                p[a] = 1'b1;
                p[b] = 1'b1;
                len = $urandom_range(1, 2);
            end else begin
                p = 5'd0;
                p[1 + $urandom_range(0, 3)] = 1'b1;
                len = $urandom_range(1, 30);
            end
            repeat (len) drive(p);
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
        end

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end of test expected one before %0t", $time);
        $fatal(1);
    end

endmodule
